// File: rtl/sched_pkg.sv
// Shared types and constants for the dual-issue scheduler.
package sched_pkg;

    localparam int unsigned NUM_SLOTS    = 2;
    localparam int unsigned NUM_REGS     = 32;
    localparam int unsigned REG_AW       = 5;
    localparam int unsigned DEF_ALU_LAT  = 1;
    localparam int unsigned DEF_MUL_LAT  = 2;
    localparam int unsigned DEF_LOAD_LAT = 3;
    localparam int unsigned DEF_CNT_W    = 2;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_BRANCH = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_MUL    = 3'd4,
        CLS_DIV    = 3'd5,
        CLS_CSR    = 3'd6,
        CLS_OTHER  = 3'd7
    } inst_class_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SOLO  = 2'd2
    } sched_state_e;

    // One queue head as seen by the scheduler.
    typedef struct packed {
        logic              valid;
        inst_class_e       cls;
        logic              exc;
        logic              rs1_en;
        logic [REG_AW-1:0] rs1;
        logic              rs2_en;
        logic [REG_AW-1:0] rs2;
        logic              rd_en;
        logic [REG_AW-1:0] rd;
    } slot_t;

    // Instructions that must run alone on a drained pipeline.
    function automatic logic is_serial(slot_t s);
        return (s.cls == CLS_CSR) || (s.cls == CLS_OTHER) || s.exc;
    endfunction

    function automatic logic is_mem(inst_class_e c);
        return (c == CLS_LOAD) || (c == CLS_STORE);
    endfunction

    function automatic logic is_muldiv(inst_class_e c);
        return (c == CLS_MUL) || (c == CLS_DIV);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register latency counters; a register is ready when its counter is 0.
module reg_scoreboard
    import sched_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clr,
    input  logic                                 dec_en,
    input  logic [NUM_SLOTS-1:0]                 set_en,
    input  logic [NUM_SLOTS-1:0][REG_AW-1:0]     set_addr,
    input  logic [NUM_SLOTS-1:0][CNT_W-1:0]      set_lat,
    output logic [NUM_REGS-1:0]                  ready_c,
    output logic                                 all_clear_c
);

    logic [CNT_W-1:0] cnt_q [1:NUM_REGS-1];
    logic [CNT_W-1:0] cnt_d [1:NUM_REGS-1];

    // Decrement, then loads (slot 1 last so it wins), then flush clear.
    always_comb begin
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (dec_en && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
            for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
                if (set_en[s] && (set_addr[s] == REG_AW'(r))) begin
                    cnt_d[r] = set_lat[s];
                end
            end
            if (clr) begin
                cnt_d[r] = '0;
            end
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Ready bits and global drain indication; r0 is always ready.
    always_comb begin
        ready_c     = '0;
        ready_c[0]  = 1'b1;
        all_clear_c = 1'b1;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            ready_c[r] = (cnt_q[r] == '0);
            if (cnt_q[r] != '0) begin
                all_clear_c = 1'b0;
            end
        end
    end

endmodule

// File: rtl/issue_scheduler.sv
// Dual-issue scheduler: pairing rules, hazard checks and serialization FSM.
module issue_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned ALU_LAT  = DEF_ALU_LAT,
    parameter int unsigned MUL_LAT  = DEF_MUL_LAT,
    parameter int unsigned LOAD_LAT = DEF_LOAD_LAT,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [1:0]      head_valid,
    input  logic [1:0][2:0] head_class,
    input  logic [1:0]      head_is_exception,
    input  logic [1:0]      reg1_read_en,
    input  logic [1:0]      reg2_read_en,
    input  logic [1:0][4:0] reg1_read_addr,
    input  logic [1:0][4:0] reg2_read_addr,
    input  logic [1:0]      reg_write_en,
    input  logic [1:0][4:0] reg_write_addr,
    input  logic            backend_stall,
    input  logic            backend_idle,
    input  logic            div_busy,
    input  logic            priv_done,
    output logic [1:0]      invalid_en,
    output logic [1:0]      sched_state
);

    function automatic logic [CNT_W-1:0] lat_of(inst_class_e c);
        case (c)
            CLS_MUL:  return CNT_W'(MUL_LAT);
            CLS_LOAD: return CNT_W'(LOAD_LAT);
            default:  return CNT_W'(ALU_LAT);
        endcase
    endfunction

    sched_state_e state_q, state_d;

    slot_t                          slot     [NUM_SLOTS];
    logic  [NUM_SLOTS-1:0]          src_ok;
    logic  [NUM_SLOTS-1:0]          div_blk;
    logic  [NUM_SLOTS-1:0]          ser;
    logic  [NUM_REGS-1:0]           reg_ready_c;
    logic                           all_clear_c;
    logic                           raw, waw, pair_ok, s0_base;
    logic  [1:0]                    issue;
    logic  [NUM_SLOTS-1:0]          set_en;
    logic  [NUM_SLOTS-1:0][REG_AW-1:0] set_addr;
    logic  [NUM_SLOTS-1:0][CNT_W-1:0]  set_lat;

    // Unpack queue heads and per-slot readiness.
    always_comb begin
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            slot[i].valid  = head_valid[i];
            slot[i].cls    = inst_class_e'(head_class[i]);
            slot[i].exc    = head_is_exception[i];
            slot[i].rs1_en = reg1_read_en[i];
            slot[i].rs1    = reg1_read_addr[i];
            slot[i].rs2_en = reg2_read_en[i];
            slot[i].rs2    = reg2_read_addr[i];
            slot[i].rd_en  = reg_write_en[i];
            slot[i].rd     = reg_write_addr[i];
            src_ok[i]  = (!slot[i].rs1_en || reg_ready_c[slot[i].rs1]) &&
                         (!slot[i].rs2_en || reg_ready_c[slot[i].rs2]);
            div_blk[i] = (slot[i].cls == CLS_DIV) && div_busy;
            ser[i]     = is_serial(slot[i]);
        end
    end

    // Intra-pair hazards and structural pairing limits for slot 1.
    always_comb begin
        raw = slot[0].rd_en && (slot[0].rd != '0) &&
              ((slot[1].rs1_en && (slot[1].rs1 == slot[0].rd)) ||
               (slot[1].rs2_en && (slot[1].rs2 == slot[0].rd)));
        waw = slot[0].rd_en && slot[1].rd_en && (slot[0].rd != '0) &&
              (slot[0].rd == slot[1].rd);
        pair_ok = slot[1].valid && src_ok[1] && !div_blk[1] && !raw && !waw &&
                  !(is_mem(slot[0].cls) && is_mem(slot[1].cls)) &&
                  !(is_muldiv(slot[0].cls) && is_muldiv(slot[1].cls)) &&
                  !ser[0] && !ser[1];
        s0_base = slot[0].valid && !backend_stall && src_ok[0] && !div_blk[0];
    end

    // Next state and issue decision.
    always_comb begin
        state_d = state_q;
        issue   = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (slot[0].valid && ser[0]) begin
                    state_d = ST_DRAIN;
                end else if (s0_base) begin
                    issue[0] = 1'b1;
                    issue[1] = pair_ok;
                end
            end
            ST_DRAIN: begin
                if (s0_base && all_clear_c && backend_idle) begin
                    issue   = 2'b01;
                    state_d = ST_SOLO;
                end
            end
            ST_SOLO: begin
                if (priv_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
            issue   = 2'b00;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Dequeue strobes are combinational and forced low while in reset.
    assign invalid_en  = rst ? issue : 2'b00;
    assign sched_state = state_q;

    // Scoreboard load ports follow the issued slots.
    always_comb begin
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            set_en[i]   = invalid_en[i] && slot[i].rd_en;
            set_addr[i] = slot[i].rd;
            set_lat[i]  = lat_of(slot[i].cls);
        end
    end

    reg_scoreboard #(
        .CNT_W (CNT_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .clr         (flush),
        .dec_en      (!backend_stall),
        .set_en      (set_en),
        .set_addr    (set_addr),
        .set_lat     (set_lat),
        .ready_c     (reg_ready_c),
        .all_clear_c (all_clear_c)
    );

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed and random checks of issue_scheduler against a timestamp-based model.
module tb_issue_scheduler;
    import sched_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [1:0]      head_valid;
    logic [1:0][2:0] head_class;
    logic [1:0]      head_is_exception;
    logic [1:0]      reg1_read_en, reg2_read_en;
    logic [1:0][4:0] reg1_read_addr, reg2_read_addr;
    logic [1:0]      reg_write_en;
    logic [1:0][4:0] reg_write_addr;
    logic            backend_stall, backend_idle, div_busy, priv_done;
    logic [1:0]      invalid_en;
    logic [1:0]      sched_state;

    always #5 clk = ~clk;

    issue_scheduler dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .head_valid        (head_valid),
        .head_class        (head_class),
        .head_is_exception (head_is_exception),
        .reg1_read_en      (reg1_read_en),
        .reg2_read_en      (reg2_read_en),
        .reg1_read_addr    (reg1_read_addr),
        .reg2_read_addr    (reg2_read_addr),
        .reg_write_en      (reg_write_en),
        .reg_write_addr    (reg_write_addr),
        .backend_stall     (backend_stall),
        .backend_idle      (backend_idle),
        .div_busy          (div_busy),
        .priv_done         (priv_done),
        .invalid_en        (invalid_en),
        .sched_state       (sched_state)
    );

    int n_pass = 0;
    int n_fail = 0;
    int n_checks = 0;

    // Model: a register becomes readable once 'tick' (count of non-stalled
    // edges) reaches ready_at[r]. mode: 0 idle, 1 drain, 2 solo.
    int ready_at [32];
    int tick;
    int mode;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit rdy(input logic en, input logic [4:0] a);
        return !en || (ready_at[a] <= tick);
    endfunction

    function automatic bit ser(input int i);
        return (head_class[i] == 3'(CLS_CSR)) || (head_class[i] == 3'(CLS_OTHER)) ||
               head_is_exception[i];
    endfunction

    function automatic bit memc(input int i);
        return (head_class[i] == 3'(CLS_LOAD)) || (head_class[i] == 3'(CLS_STORE));
    endfunction

    function automatic bit mdc(input int i);
        return (head_class[i] == 3'(CLS_MUL)) || (head_class[i] == 3'(CLS_DIV));
    endfunction

    function automatic bit srcs_ok(input int i);
        return rdy(reg1_read_en[i], reg1_read_addr[i]) && rdy(reg2_read_en[i], reg2_read_addr[i]) &&
               !((head_class[i] == 3'(CLS_DIV)) && div_busy);
    endfunction

    function automatic int lat(input int i);
        if (head_class[i] == 3'(CLS_LOAD)) return 3;
        if (head_class[i] == 3'(CLS_MUL)) return 2;
        return 1;
    endfunction

    function automatic logic [1:0] model_issue();
        bit ok1, clear;
        logic [4:0] rd0;
        if (!rst || flush || backend_stall || !head_valid[0] || mode == 2) return 2'b00;
        if (mode == 1) begin
            clear = 1'b1;
            for (int r = 0; r < 32; r++) if (ready_at[r] > tick) clear = 1'b0;
            return (clear && backend_idle && srcs_ok(0)) ? 2'b01 : 2'b00;
        end
        if (ser(0) || !srcs_ok(0)) return 2'b00;
        ok1 = head_valid[1] && srcs_ok(1) && !ser(1) && !(memc(0) && memc(1)) && !(mdc(0) && mdc(1));
        rd0 = reg_write_addr[0];
        if (reg_write_en[0] && rd0 != 5'd0 &&
            ((reg1_read_en[1] && reg1_read_addr[1] == rd0) ||
             (reg2_read_en[1] && reg2_read_addr[1] == rd0) ||
             (reg_write_en[1] && reg_write_addr[1] == rd0)))
            ok1 = 1'b0;
        return {ok1, 1'b1};
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) ready_at[r] = 0;
        tick = 0;
        mode = 0;
    endtask

    // Check one cycle (starting at a negedge), then advance the model past the posedge.
    task automatic step(input string tag, input int want);
        logic [1:0] exp;
        int nm;
        #1;
        exp = model_issue();
        if (want >= 0) chk({tag, "/lit"}, 32'(invalid_en), 32'(want));
        chk({tag, "/inv"}, 32'(invalid_en), 32'(exp));
        chk({tag, "/state"}, 32'(sched_state), 32'(mode));
        nm = mode;
        if (mode == 0 && head_valid[0] && ser(0)) nm = 1;
        if (mode == 1 && exp[0]) nm = 2;
        if (mode == 2 && priv_done) nm = 0;
        if (flush) nm = 0;
        @(posedge clk);
        mode = nm;
        if (!backend_stall) begin
            for (int s = 0; s < 2; s++)
                if (exp[s] && reg_write_en[s] && reg_write_addr[s] != 5'd0)
                    ready_at[reg_write_addr[s]] = tick + 1 + lat(s);
            tick++;
        end
        if (flush) for (int r = 0; r < 32; r++) ready_at[r] = 0;
        @(negedge clk);
    endtask

    task automatic quiet();
        flush = 0; head_valid = 0; head_class = 0; head_is_exception = 0;
        reg1_read_en = 0; reg2_read_en = 0; reg1_read_addr = 0; reg2_read_addr = 0;
        reg_write_en = 0; reg_write_addr = 0;
        backend_stall = 0; backend_idle = 1; div_busy = 0; priv_done = 0;
    endtask

    task automatic set_slot(input int i, input inst_class_e c, input logic we, input logic [4:0] rd,
                            input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
        head_valid[i] = 1'b1; head_class[i] = c; head_is_exception[i] = 1'b0;
        reg_write_en[i] = we; reg_write_addr[i] = rd;
        reg1_read_en[i] = e1; reg1_read_addr[i] = a1;
        reg2_read_en[i] = e2; reg2_read_addr[i] = a2;
    endtask

    task automatic gap(input int n);
        head_valid = 2'b00;
        for (int k = 0; k < n; k++) step("gap", 0);
    endtask

    initial begin
        quiet();
        rst = 1'b0;
        set_slot(0, CLS_ALU, 1, 5'd1, 1, 5'd2, 0, 5'd0);
        set_slot(1, CLS_ALU, 1, 5'd3, 1, 5'd4, 0, 5'd0);
        #1;
        chk("reset/inv", 32'(invalid_en), 32'd0);
        chk("reset/state", 32'(sched_state), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Independent ALU pair, then a dependent ALU op waits one cycle.
        step("alu_pair", 3);
        head_valid = 2'b00;
        set_slot(0, CLS_ALU, 1, 5'd6, 1, 5'd1, 0, 5'd0);
        step("alu_dep_wait", 0);
        step("alu_dep_go", 1);
        gap(2);

        // Load-use: three stalled-for-data cycles, four with a backend stall.
        set_slot(0, CLS_LOAD, 1, 5'd5, 1, 5'd2, 0, 5'd0);
        set_slot(1, CLS_ALU, 1, 5'd8, 1, 5'd5, 0, 5'd0);
        step("ld_pair", 1);
        head_valid = 2'b00;
        set_slot(0, CLS_ALU, 1, 5'd8, 1, 5'd5, 0, 5'd0);
        for (int k = 0; k < 3; k++) step("ld_wait", 0);
        step("ld_go", 1);
        set_slot(0, CLS_LOAD, 1, 5'd5, 1, 5'd2, 0, 5'd0);
        head_valid = 2'b01;
        step("ld2", 1);
        set_slot(0, CLS_ALU, 1, 5'd8, 1, 5'd5, 0, 5'd0);
        for (int k = 0; k < 4; k++) begin
            backend_stall = (k == 1);
            step("ld2_wait", 0);
        end
        backend_stall = 0;
        step("ld2_go", 1);
        gap(2);

        // Single LSU: store + load split over two cycles.
        set_slot(0, CLS_STORE, 0, 5'd0, 1, 5'd2, 1, 5'd9);
        set_slot(1, CLS_LOAD, 1, 5'd10, 1, 5'd11, 0, 5'd0);
        step("st_ld", 1);
        head_valid = 2'b00;
        set_slot(0, CLS_LOAD, 1, 5'd10, 1, 5'd11, 0, 5'd0);
        step("ld_alone", 1);
        gap(4);

        // CSR serialization: drain, solo grant, back to idle.
        set_slot(0, CLS_CSR, 1, 5'd12, 1, 5'd2, 0, 5'd0);
        set_slot(1, CLS_ALU, 1, 5'd13, 1, 5'd2, 0, 5'd0);
        backend_idle = 0;
        step("csr_enter", 0);
        step("csr_drain", 0);
        backend_idle = 1;
        step("csr_grant", 1);
        set_slot(0, CLS_ALU, 1, 5'd14, 1, 5'd2, 0, 5'd0);
        set_slot(1, CLS_ALU, 1, 5'd15, 1, 5'd3, 0, 5'd0);
        step("solo_hold", 0);
        priv_done = 1;
        step("solo_done", 0);
        priv_done = 0;
        step("pair_after", 3);
        gap(2);

        // Flush clears a pending multiply result.
        set_slot(0, CLS_MUL, 1, 5'd7, 1, 5'd2, 0, 5'd0);
        step("mul", 1);
        set_slot(0, CLS_ALU, 1, 5'd13, 1, 5'd7, 0, 5'd0);
        flush = 1;
        step("flush", 0);
        flush = 0;
        step("after_flush", 1);
        gap(4);

        // Asynchronous reset while draining.
        set_slot(0, CLS_CSR, 1, 5'd12, 0, 5'd0, 0, 5'd0);
        backend_idle = 0;
        step("csr2_enter", 0);
        step("csr2_drain", 0);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst/state", 32'(sched_state), 32'd0);
        chk("async_rst/inv", 32'(invalid_en), 32'd0);
        quiet();
        set_slot(0, CLS_ALU, 1, 5'd1, 1, 5'd2, 0, 5'd0);
        set_slot(1, CLS_ALU, 1, 5'd3, 1, 5'd4, 0, 5'd0);
        #1;
        chk("in_rst/inv", 32'(invalid_en), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step("post_rst", 3);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 2; i++) begin
                head_valid[i]        = 1'($urandom_range(0, 3) != 0);
                head_class[i]        = 3'($urandom_range(0, 7));
                head_is_exception[i] = 1'($urandom_range(0, 15) == 0);
                reg1_read_en[i]      = 1'($urandom_range(0, 1));
                reg2_read_en[i]      = 1'($urandom_range(0, 1));
                reg1_read_addr[i]    = 5'($urandom_range(0, 7));
                reg2_read_addr[i]    = 5'($urandom_range(0, 7));
                reg_write_addr[i]    = 5'($urandom_range(0, 7));
                reg_write_en[i]      = 1'($urandom_range(0, 1)) &&
                                       (head_class[i] inside {3'(CLS_ALU), 3'(CLS_BRANCH),
                                        3'(CLS_LOAD), 3'(CLS_MUL), 3'(CLS_CSR)});
            end
            backend_stall = ($urandom_range(0, 7) == 0);
            flush         = ($urandom_range(0, 31) == 0);
            backend_idle  = 1'($urandom_range(0, 1));
            div_busy      = ($urandom_range(0, 3) == 0);
            priv_done     = ($urandom_range(0, 3) == 0);
            step("rand", -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
